// File: rtl/bus_slave_mem.sv
// Word-addressed memory slave behind one crossbar slave port; ack is a single-cycle pulse LATENCY+1 cycles after req is sampled.
// No backpressure: one transaction at a time, req is held by the master until ack, and req is ignored outside IDLE.
module bus_slave_mem #(
  parameter int DEPTH_LOG2 = 8,
  parameter int LATENCY    = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        cmd,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        ack,
  output logic [31:0] rdata,
  output logic        busy
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_ACK  = 2'd2;
  localparam logic [3:0] LAT     = 4'(LATENCY);

  logic [1:0]            state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic                  cmd_q, cmd_d;
  logic [DEPTH_LOG2-1:0] idx_q, idx_d;
  logic [31:0]           wdata_q, wdata_d;
  logic [31:0]           rdata_q, rdata_d;
  logic                  ack_q, busy_q;
  logic                  enter_ack;
  logic [DEPTH_LOG2-1:0] req_idx;
  logic                  unused_addr_bits;

  logic [31:0] mem_q [0:(1<<DEPTH_LOG2)-1];

  assign req_idx          = addr[DEPTH_LOG2+1:2];
  assign unused_addr_bits = ^{addr[31:DEPTH_LOG2+2], addr[1:0]};

  // The *_d capture values feed the memory access, so LATENCY=0 uses the live inputs directly.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    cmd_d     = cmd_q;
    idx_d     = idx_q;
    wdata_d   = wdata_q;
    enter_ack = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req) begin
          cmd_d   = cmd;
          idx_d   = req_idx;
          wdata_d = wdata;
          if (LAT == 4'd0) begin
            state_d   = ST_ACK;
            enter_ack = 1'b1;
          end else begin
            cnt_d   = LAT;
            state_d = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d   = ST_ACK;
          enter_ack = 1'b1;
        end
      end
      ST_ACK:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    rdata_d = rdata_q;
    if (enter_ack && !cmd_d) begin
      rdata_d = mem_q[idx_d];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      cmd_q   <= 1'b0;
      idx_q   <= '0;
      wdata_q <= 32'h0;
      rdata_q <= 32'h0;
      ack_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cmd_q   <= cmd_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      ack_q   <= (state_d == ST_ACK);
      busy_q  <= (state_d != ST_IDLE);
    end
  end

  // Array is never cleared; reset only blocks a write that would land on the reset edge.
  always_ff @(posedge clk) begin
    if (!rst && enter_ack && cmd_d) begin
      mem_q[idx_d] <= wdata_d;
    end
  end

  assign ack   = ack_q;
  assign rdata = rdata_q;
  assign busy  = busy_q;

endmodule
